// File: rtl/mac_chain_if.sv
// mac_chain_if -- bundles the streaming, kernel-load and result signals of
// mac_chain.
//   img/val/rdy      : input beat stream, channel c at img[c*IMG_WIDTH +: IMG_WIDTH]
//   ker_wr/addr/data : shadow weight write port
//   ker_commit       : request to copy the shadow bank into the active bank
//   result/res_val   : dot product output (result is 0 when res_val is 0)
//   drop             : sticky flag, a beat was offered while rdy was low
// master = producer/consumer side, slave = mac_chain.
interface mac_chain_if #(
  parameter int KER_WIDTH = 16,
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int ACC_WIDTH = IMG_WIDTH + KER_WIDTH + $clog2(IMG_NB) + 1,
  parameter int AW        = (IMG_NB > 1) ? $clog2(IMG_NB) : 1
);
  logic [IMG_WIDTH*IMG_NB-1:0] img;
  logic                        val;
  logic                        rdy;
  logic                        ker_wr;
  logic [AW-1:0]               ker_addr;
  logic [KER_WIDTH-1:0]        ker_data;
  logic                        ker_commit;
  logic [ACC_WIDTH-1:0]        result;
  logic                        res_val;
  logic                        drop;

  modport master (
    output img, val, ker_wr, ker_addr, ker_data, ker_commit,
    input  rdy, result, res_val, drop
  );

  modport slave (
    input  img, val, ker_wr, ker_addr, ker_data, ker_commit,
    output rdy, result, res_val, drop
  );
endinterface

// File: rtl/mac_chain.sv
// mac_chain -- systolic multiply-accumulate chain. Each accepted beat yields
// sum_c ker_active[c]*img[c]. Channel c is skewed by c*STAGE_LAT cycles so it
// meets the partial sum travelling down the chain; every stage adds its
// product and holds the sum for STAGE_LAT registers.
// Weights are double-buffered: writes land in a shadow bank, and a commit
// stalls input (rdy=0) until the chain is empty, then copies shadow->active.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : mac_chain_if slave modport (stream in, kernel load, result out)
module mac_chain #(
  parameter int KER_WIDTH = 16,
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int STAGE_LAT = 6,
  parameter int ACC_WIDTH = IMG_WIDTH + KER_WIDTH + $clog2(IMG_NB) + 1,
  parameter int AW        = (IMG_NB > 1) ? $clog2(IMG_NB) : 1
) (
  input  logic       clk,
  input  logic       rst,
  mac_chain_if.slave bus
);
  localparam int LAT = IMG_NB * STAGE_LAT;
  localparam int PW  = IMG_WIDTH + KER_WIDTH;

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_copy;
  logic                 w_rdy;
  logic                 w_accept;
  logic [LAT-1:0]       r_vld_p;
  logic                 r_drop;
  logic [IMG_NB-1:0]    w_wr_hit;
  logic [KER_WIDTH-1:0] r_ker_shd [IMG_NB];
  logic [KER_WIDTH-1:0] r_ker_act [IMG_NB];
  logic [IMG_WIDTH-1:0] w_pix     [IMG_NB];
  logic [ACC_WIDTH-1:0] w_psum    [IMG_NB];

  // rdy is a pure decode of the state flop, so it is glitch-free and registered.
  assign w_rdy    = (r_state == S_RUN);
  assign w_accept = bus.val && w_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  // The copy waits for an empty valid pipe, so every in-flight beat finishes
  // with the weight set it started with.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      S_RUN:   if (bus.ker_commit) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_vld_p == '0) begin
                 w_copy      = 1'b1;
                 w_state_nxt = S_RUN;
               end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_vld_p[0] <= w_accept;
      for (int k = 1; k < LAT; k++) r_vld_p[k] <= r_vld_p[k-1];
      if (bus.val && !w_rdy) r_drop <= 1'b1;
    end
  end

  // Addresses at or beyond IMG_NB never match, so such writes are dropped.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < IMG_NB; i++)
      w_wr_hit[i] = bus.ker_wr && (bus.ker_addr == AW'(i));
  end

  // A write landing in the copy cycle is forwarded so the new value is copied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IMG_NB; i++) begin
        r_ker_shd[i] <= '0;
        r_ker_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IMG_NB; i++) begin
        if (w_wr_hit[i]) r_ker_shd[i] <= bus.ker_data;
        if (w_copy)      r_ker_act[i] <= w_wr_hit[i] ? bus.ker_data : r_ker_shd[i];
      end
    end
  end

  genvar c;
  generate
    for (c = 0; c < IMG_NB; c++) begin : g_stage
      logic [PW-1:0]        w_prod;
      logic [ACC_WIDTH-1:0] w_psum_in;
      logic [ACC_WIDTH-1:0] r_psum_p [STAGE_LAT];

      if (c == 0) begin : g_first
        assign w_pix[c]  = bus.img[c*IMG_WIDTH +: IMG_WIDTH];
        assign w_psum_in = '0;
      end else begin : g_skew
        // skew line: channel c arrives exactly when stage c-1's sum does
        logic [IMG_WIDTH-1:0] r_pix_p [c*STAGE_LAT];
        always_ff @(posedge clk) begin
          r_pix_p[0] <= bus.img[c*IMG_WIDTH +: IMG_WIDTH];
          for (int k = 1; k < c*STAGE_LAT; k++) r_pix_p[k] <= r_pix_p[k-1];
        end
        assign w_pix[c]  = r_pix_p[c*STAGE_LAT-1];
        assign w_psum_in = w_psum[c-1];
      end

      assign w_prod = {{KER_WIDTH{1'b0}}, w_pix[c]} * {{IMG_WIDTH{1'b0}}, r_ker_act[c]};

      // stage c: accumulate, then hold for STAGE_LAT registers
      always_ff @(posedge clk) begin
        r_psum_p[0] <= w_psum_in + {{(ACC_WIDTH-PW){1'b0}}, w_prod};
        for (int k = 1; k < STAGE_LAT; k++) r_psum_p[k] <= r_psum_p[k-1];
      end
      assign w_psum[c] = r_psum_p[STAGE_LAT-1];
    end
  endgenerate

  assign bus.rdy     = w_rdy;
  assign bus.res_val = r_vld_p[LAT-1];
  assign bus.result  = r_vld_p[LAT-1] ? w_psum[IMG_NB-1] : '0;
  assign bus.drop    = r_drop;
endmodule

// File: tb/tb_mac_chain.sv
// tb_mac_chain -- directed sequence with randomized pixels and weights for
// mac_chain. A transaction-level model (queue of expected dot products with
// due cycles, plus shadow/active weight arrays and a commit-pending flag)
// predicts rdy, res_val, result and drop every cycle.
module tb_mac_chain;
  localparam int KER_WIDTH = 16;
  localparam int IMG_WIDTH = 16;
  localparam int IMG_NB    = 3;
  localparam int STAGE_LAT = 6;
  localparam int ACC_WIDTH = IMG_WIDTH + KER_WIDTH + $clog2(IMG_NB) + 1;
  localparam int AW        = (IMG_NB > 1) ? $clog2(IMG_NB) : 1;
  localparam int LAT       = IMG_NB * STAGE_LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_chain_if #(.KER_WIDTH(KER_WIDTH), .IMG_WIDTH(IMG_WIDTH), .IMG_NB(IMG_NB),
                 .ACC_WIDTH(ACC_WIDTH), .AW(AW)) bus ();

  mac_chain #(.KER_WIDTH(KER_WIDTH), .IMG_WIDTH(IMG_WIDTH), .IMG_NB(IMG_NB),
              .STAGE_LAT(STAGE_LAT), .ACC_WIDTH(ACC_WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                   due;
    logic [ACC_WIDTH-1:0] res;
  } exp_t;

  exp_t                 exp_q[$];
  logic [KER_WIDTH-1:0] m_shd [IMG_NB];
  logic [KER_WIDTH-1:0] m_act [IMG_NB];
  logic                 m_rdy, m_drain, m_drop;
  int                   m_last_due;
  int                   cyc, n_cmp, n_err, n_acc, n_res, n0;
  logic [ACC_WIDTH-1:0] last_res;
  logic [ACC_WIDTH-1:0] big_res;

  function automatic logic [ACC_WIDTH-1:0] dot(input logic [IMG_WIDTH*IMG_NB-1:0] im);
    logic [63:0] s;
    s = '0;
    for (int c = 0; c < IMG_NB; c++)
      s += 64'(m_act[c]) * 64'(im[c*IMG_WIDTH +: IMG_WIDTH]);
    return s[ACC_WIDTH-1:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < IMG_NB; i++) begin
      m_shd[i] = '0;
      m_act[i] = '0;
    end
    m_rdy      = 1'b1;
    m_drain    = 1'b0;
    m_drop     = 1'b0;
    m_last_due = -1;
  endtask

  // Called with this cycle's inputs applied, before the closing edge.
  task automatic model_edge();
    if (bus.val && !m_rdy) m_drop = 1'b1;
    if (bus.val && m_rdy) begin
      exp_q.push_back('{due: cyc + LAT, res: dot(bus.img)});
      m_last_due = cyc + LAT;
      n_acc++;
    end
    if (bus.ker_wr && int'(bus.ker_addr) < IMG_NB) m_shd[bus.ker_addr] = bus.ker_data;
    if (m_drain) begin
      if (m_last_due < cyc) begin
        m_act   = m_shd;
        m_drain = 1'b0;
      end
    end else if (bus.ker_commit) begin
      m_drain = 1'b1;
    end
    m_rdy = !m_drain;
  endtask

  task automatic check_outputs();
    logic                 exp_v;
    logic [ACC_WIDTH-1:0] exp_r;
    exp_v = 1'b0;
    exp_r = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_v = 1'b1;
      exp_r = exp_q[0].res;
      void'(exp_q.pop_front());
    end
    if (bus.res_val === 1'b1) begin
      n_res++;
      last_res = bus.result;
    end
    n_cmp++;
    assert (bus.res_val === exp_v) else begin
      n_err++;
      $error("FAIL res_val cyc=%0d observed=%b expected=%b", cyc, bus.res_val, exp_v);
    end
    n_cmp++;
    assert (bus.result === exp_r) else begin
      n_err++;
      $error("FAIL result cyc=%0d observed=%h expected=%h", cyc, bus.result, exp_r);
    end
    n_cmp++;
    assert (bus.rdy === m_rdy) else begin
      n_err++;
      $error("FAIL rdy cyc=%0d observed=%b expected=%b", cyc, bus.rdy, m_rdy);
    end
    n_cmp++;
    assert (bus.drop === m_drop) else begin
      n_err++;
      $error("FAIL drop cyc=%0d observed=%b expected=%b", cyc, bus.drop, m_drop);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic rand_img();
    for (int c = 0; c < IMG_NB; c++)
      bus.img[c*IMG_WIDTH +: IMG_WIDTH] = IMG_WIDTH'($urandom());
  endtask

  task automatic write_ker(input int addr, input int data);
    bus.ker_wr   = 1'b1;
    bus.ker_addr = AW'(addr);
    bus.ker_data = KER_WIDTH'(data);
    tick();
    bus.ker_wr = 1'b0;
  endtask

  task automatic commit_wait();
    bus.ker_commit = 1'b1;
    tick();
    bus.ker_commit = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  task automatic apply_reset();
    bus.val        = 1'b0;
    bus.ker_wr     = 1'b0;
    bus.ker_commit = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    assert (bus.res_val === 1'b0) else begin
      n_err++;
      $error("FAIL rst_res_val observed=%b expected=0", bus.res_val);
    end
    n_cmp++;
    assert (bus.result === '0) else begin
      n_err++;
      $error("FAIL rst_result observed=%h expected=0", bus.result);
    end
    n_cmp++;
    assert (bus.drop === 1'b0) else begin
      n_err++;
      $error("FAIL rst_drop observed=%b expected=0", bus.drop);
    end
    model_clear();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.img        = '0;
    bus.val        = 1'b0;
    bus.ker_wr     = 1'b0;
    bus.ker_addr   = '0;
    bus.ker_data   = '0;
    bus.ker_commit = 1'b0;
    cyc = 0; n_cmp = 0; n_err = 0; n_acc = 0; n_res = 0;
    last_res = '0;
    big_res  = 'h2FFFA0003;
    model_clear();

    apply_reset();
    repeat (3) tick();

    // weights 2,3,4 and a single beat (5,7,9)
    write_ker(0, 2);
    write_ker(1, 3);
    write_ker(2, 4);
    commit_wait();
    n0 = n_res;
    bus.val = 1'b1;
    bus.img = {16'd9, 16'd7, 16'd5};
    tick();
    bus.val = 1'b0;
    rand_img();
    repeat (LAT + 3) tick();
    n_cmp++;
    assert (n_res - n0 == 1 && last_res === ACC_WIDTH'(67)) else begin
      n_err++;
      $error("FAIL single_beat count=%0d result=%0d expected count=1 result=67", n_res - n0, last_res);
    end

    // 20 back-to-back random beats
    n0 = n_res;
    bus.val = 1'b1;
    repeat (20) begin
      rand_img();
      tick();
    end
    bus.val = 1'b0;
    repeat (LAT + 2) tick();
    n_cmp++;
    assert (n_res - n0 == 20) else begin
      n_err++;
      $error("FAIL b2b_count observed=%0d expected=20", n_res - n0);
    end

    // stream under (1,1,1) while loading (2,3,4), commit mid-stream
    write_ker(0, 1);
    write_ker(1, 1);
    write_ker(2, 1);
    commit_wait();
    bus.val = 1'b1;
    for (int i = 0; i < IMG_NB; i++) begin
      rand_img();
      bus.ker_wr   = 1'b1;
      bus.ker_addr = AW'(i);
      bus.ker_data = KER_WIDTH'(2 + i);
      tick();
    end
    bus.ker_wr     = 1'b0;
    rand_img();
    bus.ker_commit = 1'b1;
    tick();
    bus.ker_commit = 1'b0;
    bus.val        = 1'b0;
    repeat (LAT + 3) tick();
    bus.val = 1'b1;
    repeat (6) begin
      rand_img();
      tick();
    end
    bus.val = 1'b0;
    repeat (LAT + 2) tick();

    // hold val through a drain with random shadow writes and a repeated commit
    bus.val        = 1'b1;
    rand_img();
    bus.ker_commit = 1'b1;
    tick();
    for (int i = 0; i < LAT + 3; i++) begin
      rand_img();
      bus.ker_commit = (i == 3);
      bus.ker_wr     = 1'b1;
      bus.ker_addr   = AW'($urandom_range(0, 3));
      bus.ker_data   = KER_WIDTH'($urandom());
      tick();
    end
    bus.ker_commit = 1'b0;
    bus.ker_wr     = 1'b0;
    repeat (4) begin
      rand_img();
      tick();
    end
    bus.val = 1'b0;
    repeat (LAT + 2) tick();
    n_cmp++;
    assert (n_res == n_acc && bus.drop === 1'b1) else begin
      n_err++;
      $error("FAIL drop_count results=%0d accepted=%0d drop=%b expected drop=1", n_res, n_acc, bus.drop);
    end

    // all-ones corner
    for (int i = 0; i < IMG_NB; i++) write_ker(i, 16'hFFFF);
    commit_wait();
    bus.val = 1'b1;
    bus.img = '1;
    tick();
    bus.val = 1'b0;
    repeat (LAT + 2) tick();
    n_cmp++;
    assert (last_res === big_res) else begin
      n_err++;
      $error("FAIL max_result observed=%h expected=%h", last_res, big_res);
    end

    // reset with 5 beats in flight and a drain pending
    bus.val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_img();
      bus.ker_commit = (i == 4);
      tick();
    end
    bus.val        = 1'b0;
    bus.ker_commit = 1'b0;
    tick();
    apply_reset();
    repeat (2) tick();
    n0 = n_res;
    bus.val = 1'b1;
    rand_img();
    tick();
    bus.val = 1'b0;
    repeat (LAT + 2) tick();
    n_cmp++;
    assert (n_res - n0 == 1 && last_res === '0) else begin
      n_err++;
      $error("FAIL post_reset_beat count=%0d result=%h expected count=1 result=0", n_res - n0, last_res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
